// File: rtl/telemetry_sched_if.sv
// Handshake and data bundle between the telemetry scheduler, the A2D readings and UART_tx.
// The scheduler side uses the master modport; the environment (readings + UART) uses slave.
interface telemetry_sched_if;
    logic        en;
    logic [11:0] batt;
    logic [11:0] curr;
    logic [11:0] torque;
    logic        tx_done;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        busy;
    logic        ovr;

    modport master (
        input  en, batt, curr, torque, tx_done,
        output trmt, tx_data, busy, ovr
    );

    modport slave (
        output en, batt, curr, torque, tx_done,
        input  trmt, tx_data, busy, ovr
    );
endinterface

// File: rtl/telemetry_sched.sv
// Periodic telemetry scheduler: snapshots readings, frames them into a byte packet and
// sequences it through UART_tx. Define CHECKSUM_EN to append an inverted-sum checksum byte.
module telemetry_sched #(
    parameter int FAST_SIM    = 0,
    parameter int PERIOD_FULL = 1048576,
    parameter int PERIOD_FAST = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    telemetry_sched_if.master bus
);

    localparam int PERIOD = (FAST_SIM != 0) ? PERIOD_FAST : PERIOD_FULL;
    localparam int CNT_W  = $clog2(PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
`ifdef CHECKSUM_EN
    localparam logic [3:0] LAST_IDX = 4'd8;
`else
    localparam logic [3:0] LAST_IDX = 4'd7;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_idx;
    logic [3:0]       w_idx_nxt;
    logic [11:0]      r_batt;
    logic [11:0]      r_curr;
    logic [11:0]      r_torque;
    logic             r_trmt;
    logic [7:0]       r_tx_data;
    logic             r_busy;
    logic             r_ovr;
    logic             w_tick;
    logic             w_load;
    logic             w_advance;

`ifdef CHECKSUM_EN
    function automatic logic [7:0] checksum(input logic [11:0] b, input logic [11:0] c,
                                            input logic [11:0] t);
        logic [7:0] s;
        s = {4'h0, b[11:8]} + b[7:0] + {4'h0, c[11:8]} + c[7:0] + {4'h0, t[11:8]} + t[7:0];
        return ~s;
    endfunction
`endif

    function automatic logic [7:0] pkt_byte(input logic [3:0] idx, input logic [11:0] b,
                                            input logic [11:0] c, input logic [11:0] t);
        logic [7:0] v;
        case (idx)
            4'd0:    v = 8'hAA;
            4'd1:    v = 8'h55;
            4'd2:    v = {4'h0, b[11:8]};
            4'd3:    v = b[7:0];
            4'd4:    v = {4'h0, c[11:8]};
            4'd5:    v = c[7:0];
            4'd6:    v = {4'h0, t[11:8]};
            4'd7:    v = t[7:0];
`ifdef CHECKSUM_EN
            4'd8:    v = checksum(b, c, t);
`endif
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    assign w_tick = bus.en & (r_cnt == CNT_LAST);

    // Period timer: free-runs while enabled, parked at zero otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (!bus.en || (r_cnt == CNT_LAST)) begin
            r_cnt <= {CNT_W{1'b0}};
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and byte-index control; a tick outside IDLE is never accepted
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_state_nxt = S_SEND;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SEND: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.tx_done) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_SEND;
                        w_advance   = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next byte index
    always_comb begin
        w_idx_nxt = r_idx;
        if (w_load) begin
            w_idx_nxt = 4'd0;
        end else if (w_advance) begin
            w_idx_nxt = r_idx + 4'd1;
        end else begin
            w_idx_nxt = r_idx;
        end
    end

    // Snapshot, index and registered outputs; byte 0 is constant so the snapshot
    // need not be valid yet on the load cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_batt    <= 12'h000;
            r_curr    <= 12'h000;
            r_torque  <= 12'h000;
            r_idx     <= 4'd0;
            r_trmt    <= 1'b0;
            r_tx_data <= 8'h00;
            r_busy    <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            if (w_load) begin
                r_batt   <= bus.batt;
                r_curr   <= bus.curr;
                r_torque <= bus.torque;
            end
            r_idx  <= w_idx_nxt;
            r_trmt <= (w_state_nxt == S_SEND);
            if (w_state_nxt == S_SEND) begin
                r_tx_data <= pkt_byte(w_idx_nxt, r_batt, r_curr, r_torque);
            end
            r_busy <= (w_state_nxt != S_IDLE);
            r_ovr  <= w_tick & (r_state != S_IDLE);
        end
    end

    assign bus.trmt    = r_trmt;
    assign bus.tx_data = r_tx_data;
    assign bus.busy    = r_busy;
    assign bus.ovr     = r_ovr;

endmodule

// File: tb/tb_telemetry_sched.sv
// Self-checking bench for telemetry_sched (FAST_SIM=1) with a UART responder and a
// packet-level reference model; build with CHECKSUM_EN to exercise the 9-byte packet.
module tb_telemetry_sched;

    localparam int P  = 4096;
    localparam int DN = 10;
`ifdef CHECKSUM_EN
    localparam int NB      = 9;
    localparam int EXP_OVR = 2;
    localparam int EXP_GAP = 12288;
`else
    localparam int NB      = 8;
    localparam int EXP_OVR = 1;
    localparam int EXP_GAP = 8192;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   pcyc = 0;
    int   ovr_cnt = 0;
    int   uart_delay = DN;
    int   ucnt = 0;
    logic [7:0] q_data[$];
    int         q_time[$];
    logic       q_busy[$];

    always #5 clk = ~clk;

    telemetry_sched_if bus();

    telemetry_sched #(.FAST_SIM(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk) pcyc <= pcyc + 1;

    // UART responder and trmt/ovr monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.tx_done = 1'b1;
            ucnt = 0;
        end else begin
            if (bus.trmt === 1'b1) begin
                q_data.push_back(bus.tx_data);
                q_time.push_back(pcyc);
                q_busy.push_back(bus.busy);
                bus.tx_done = 1'b0;
                ucnt = uart_delay;
            end else if (ucnt > 0) begin
                ucnt--;
                if (ucnt == 0) bus.tx_done = 1'b1;
            end
            if (bus.ovr === 1'b1) ovr_cnt++;
        end
    end

    // Reference packet: header, three 12-bit readings split high/low, inverted byte sum
    function automatic logic [7:0] exp_byte(int i, int b, int c, int t);
        int v[9];
        int s;
        v[0] = 170; v[1] = 85;
        v[2] = b / 256; v[3] = b % 256;
        v[4] = c / 256; v[5] = c % 256;
        v[6] = t / 256; v[7] = t % 256;
        s = 0;
        for (int k = 2; k < 8; k++) s += v[k];
        v[8] = 255 - (s % 256);
        return 8'(v[i]);
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_data.delete();
        q_time.delete();
        q_busy.delete();
    endtask

    task automatic wait_bytes(input int n, input int bound, output bit ok);
        int k;
        k = 0;
        while (q_data.size() < n && k < bound) begin
            step();
            k++;
        end
        ok = (q_data.size() >= n);
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        int k;
        k = 0;
        while (bus.busy !== 1'b0 && k < bound) begin
            step();
            k++;
        end
        ok = (bus.busy === 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.en = 1'b0; bus.batt = 12'h000; bus.curr = 12'h000; bus.torque = 12'h000;
        bus.tx_done = 1'b1;
        repeat (3) step();
        total++; if (bus.trmt !== 1'b0) begin bad++; $display("FAIL rst_trmt: got %b want 0", bus.trmt); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL rst_txdata: got %h want 00", bus.tx_data); end
        total++; if (bus.ovr !== 1'b0) begin bad++; $display("FAIL rst_ovr: got %b want 0", bus.ovr); end
        rst_n = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_packet(input int b, input int c, input int t);
        bit ok;
        int t_en;
        clear_q();
        ovr_cnt = 0;
        bus.batt = 12'(b); bus.curr = 12'(c); bus.torque = 12'(t);
        bus.en = 1'b1;
        t_en = pcyc;
        wait_bytes(NB, P + NB * (DN + 1) + 50, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL pkt_timeout: got %0d bytes want %0d", q_data.size(), NB);
        end else begin
            total++;
            if (q_time[0] - t_en != P) begin
                bad++; $display("FAIL pkt_latency: got %0d want %0d", q_time[0] - t_en, P);
            end
            for (int i = 0; i < NB; i++) begin
                total++;
                if (q_data[i] !== exp_byte(i, b, c, t)) begin
                    bad++; $display("FAIL pkt_byte%0d: got %h want %h", i, q_data[i], exp_byte(i, b, c, t));
                end
                total++;
                if (q_busy[i] !== 1'b1) begin
                    bad++; $display("FAIL pkt_busy%0d: got %b want 1", i, q_busy[i]);
                end
                if (i > 0) begin
                    total++;
                    if (q_time[i] - q_time[i-1] != DN + 1) begin
                        bad++; $display("FAIL pkt_gap%0d: got %0d want %0d", i, q_time[i] - q_time[i-1], DN + 1);
                    end
                end
            end
        end
        wait_idle(DN + 5, ok);
        total++; if (!ok) begin bad++; $display("FAIL pkt_busy_drop: got %b want 0", bus.busy); end
        total++; if (ovr_cnt != 0) begin bad++; $display("FAIL pkt_ovr: got %0d want 0", ovr_cnt); end
        bus.en = 1'b0;
        step();
    endtask

    task automatic test_snapshot();
        bit ok;
        int b1, b2, c, t;
        b1 = 12'hB80; b2 = 12'h500;
        c = int'($urandom_range(0, 4095)); t = int'($urandom_range(0, 4095));
        clear_q();
        bus.batt = 12'(b1); bus.curr = 12'(c); bus.torque = 12'(t);
        bus.en = 1'b1;
        wait_bytes(3, P + 100, ok);
        bus.batt = 12'(b2);
        wait_bytes(2 * NB, 2 * P, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL snap_timeout: got %0d bytes want %0d", q_data.size(), 2 * NB);
        end else begin
            for (int i = 0; i < NB; i++) begin
                total++;
                if (q_data[i] !== exp_byte(i, b1, c, t)) begin
                    bad++; $display("FAIL snap_old%0d: got %h want %h", i, q_data[i], exp_byte(i, b1, c, t));
                end
                total++;
                if (q_data[NB+i] !== exp_byte(i, b2, c, t)) begin
                    bad++; $display("FAIL snap_new%0d: got %h want %h", i, q_data[NB+i], exp_byte(i, b2, c, t));
                end
            end
            total++;
            if (q_time[NB] - q_time[0] != P) begin
                bad++; $display("FAIL snap_period: got %0d want %0d", q_time[NB] - q_time[0], P);
            end
        end
        bus.en = 1'b0;
        wait_idle(NB * (DN + 2), ok);
        step();
    endtask

    task automatic test_en_drop();
        bit ok;
        int b, c, t, t_en;
        b = int'($urandom_range(0, 4095)); c = int'($urandom_range(0, 4095)); t = int'($urandom_range(0, 4095));
        clear_q();
        bus.batt = 12'(b); bus.curr = 12'(c); bus.torque = 12'(t);
        bus.en = 1'b1;
        wait_bytes(4, P + 100, ok);
        bus.en = 1'b0;
        wait_bytes(NB, NB * (DN + 2), ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL endrop_complete: got %0d bytes want %0d", q_data.size(), NB);
        end else begin
            for (int i = 0; i < NB; i++) begin
                total++;
                if (q_data[i] !== exp_byte(i, b, c, t)) begin
                    bad++; $display("FAIL endrop_byte%0d: got %h want %h", i, q_data[i], exp_byte(i, b, c, t));
                end
            end
        end
        repeat (10000) step();
        total++;
        if (q_data.size() != NB) begin
            bad++; $display("FAIL endrop_quiet: got %0d bytes want %0d", q_data.size(), NB);
        end
        bus.en = 1'b1;
        t_en = pcyc;
        wait_bytes(2 * NB, P + NB * (DN + 1) + 50, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL endrop_restart: got %0d bytes want %0d", q_data.size(), 2 * NB);
        end else begin
            total++;
            if (q_time[NB] - t_en != P) begin
                bad++; $display("FAIL endrop_latency: got %0d want %0d", q_time[NB] - t_en, P);
            end
            total++;
            if (q_data[NB] !== 8'hAA) begin
                bad++; $display("FAIL endrop_hdr: got %h want aa", q_data[NB]);
            end
        end
        bus.en = 1'b0;
        wait_idle(NB * (DN + 2), ok);
        step();
    endtask

    task automatic test_overrun();
        bit ok;
        int b, c, t;
        b = int'($urandom_range(0, 4095)); c = int'($urandom_range(0, 4095)); t = int'($urandom_range(0, 4095));
        clear_q();
        ovr_cnt = 0;
        uart_delay = 1000;
        bus.batt = 12'(b); bus.curr = 12'(c); bus.torque = 12'(t);
        bus.en = 1'b1;
        wait_bytes(NB, P + NB * 1001 + 100, ok);
        wait_idle(1100, ok);
        total++;
        if (ovr_cnt != EXP_OVR) begin
            bad++; $display("FAIL ovr_count: got %0d want %0d", ovr_cnt, EXP_OVR);
        end
        wait_bytes(NB + 1, 5000, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL ovr_next_timeout: got %0d bytes want %0d", q_data.size(), NB + 1);
        end else begin
            total++;
            if (q_time[NB] - q_time[0] != EXP_GAP) begin
                bad++; $display("FAIL ovr_next_gap: got %0d want %0d", q_time[NB] - q_time[0], EXP_GAP);
            end
            for (int i = 0; i < NB; i++) begin
                total++;
                if (q_data[i] !== exp_byte(i, b, c, t)) begin
                    bad++; $display("FAIL ovr_byte%0d: got %h want %h", i, q_data[i], exp_byte(i, b, c, t));
                end
            end
        end
        bus.en = 1'b0;
        rst_n = 1'b0;
        step();
        uart_delay = DN;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int b, c, t, t_rel;
        b = int'($urandom_range(0, 4095)); c = int'($urandom_range(0, 4095)); t = int'($urandom_range(0, 4095));
        clear_q();
        bus.batt = 12'(b); bus.curr = 12'(c); bus.torque = 12'(t);
        bus.en = 1'b1;
        wait_bytes(6, P + 100, ok);
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.trmt !== 1'b0) begin bad++; $display("FAIL midrst_trmt: got %b want 0", bus.trmt); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
        total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL midrst_txdata: got %h want 00", bus.tx_data); end
        clear_q();
        step();
        rst_n = 1'b1;
        t_rel = pcyc;
        wait_bytes(NB, P + NB * (DN + 1) + 50, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL midrst_timeout: got %0d bytes want %0d", q_data.size(), NB);
        end else begin
            total++;
            if (q_time[0] - t_rel != P) begin
                bad++; $display("FAIL midrst_latency: got %0d want %0d", q_time[0] - t_rel, P);
            end
            for (int i = 0; i < NB; i++) begin
                total++;
                if (q_data[i] !== exp_byte(i, b, c, t)) begin
                    bad++; $display("FAIL midrst_byte%0d: got %h want %h", i, q_data[i], exp_byte(i, b, c, t));
                end
            end
        end
        bus.en = 1'b0;
        wait_idle(NB * (DN + 2), ok);
        step();
    endtask

    initial begin
        test_reset();
        test_packet(12'hB80, 12'h123, 12'h700);
        for (int r = 0; r < 2; r++) begin
            test_packet(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                        int'($urandom_range(0, 4095)));
        end
        test_snapshot();
        test_en_drop();
        test_overrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
